// File: rtl/csr_cnt_pkg.sv
// Shared constants and types for the machine counter CSR block: address map,
// counter slot index type and event-selector width.
package csr_cnt_pkg;

    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MHPMCNT3  = 12'hB03;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_MCOUNTINH = 12'h320;
    localparam logic [11:0] CSR_MHPMEVT3  = 12'h323;
    localparam logic [11:0] CSR_HI_OFS    = 12'h080;

    localparam int EVT_SEL_W = 8;
    typedef logic [EVT_SEL_W-1:0] evt_sel_t;

    // Slot 0 is minstret, slot i (1..29) is mhpmcounter(2+i).
    typedef logic [4:0] cnt_idx_t;

    function automatic logic [11:0] cnt_adr(input cnt_idx_t slot);
        return CSR_MINSTRET + 12'(slot);
    endfunction

    function automatic logic [11:0] evt_adr(input cnt_idx_t slot);
        return CSR_MHPMEVT3 - 12'd1 + 12'(slot);
    endfunction

endpackage

// File: rtl/csr_cnt_slice.sv
// One event counter: event select, inhibit, split-half write merge and the
// sticky overflow (OF) flag, which exists only when CSR_HPM_OVF_EN is defined.
module csr_cnt_slice
    import csr_cnt_pkg::*;
#(
    parameter int CNT_W     = 64,
    parameter int N_EVT     = 8,
    parameter int FIXED_SEL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inhibit,
    input  logic [N_EVT-1:0] evt,
    input  logic             we_lo,
    input  logic             we_hi,
    input  logic             sel_we,
    input  logic [31:0]      wdata,
    output logic [CNT_W-1:0] cnt,
    output logic [31:0]      evt_rd,
    output logic             of
);

    logic [CNT_W-1:0] cnt_q;
    evt_sel_t         sel;
    logic             of_q;
    logic             evt_hit;
    logic             inc;
    logic             wrap;

    // Selector 0 and selectors beyond N_EVT never match any event line.
    always_comb begin
        evt_hit = 1'b0;
        for (int k = 0; k < N_EVT; k++) begin
            if (sel == evt_sel_t'(k + 1)) evt_hit = evt[k];
        end
    end

    assign inc  = evt_hit && !inhibit;
    assign wrap = inc && !we_lo && !we_hi && (cnt_q == {CNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst_n)      cnt_q <= '0;
        else if (we_lo) cnt_q[31:0] <= wdata;
        else if (we_hi) cnt_q[CNT_W-1:32] <= wdata[CNT_W-33:0];
        else if (inc)   cnt_q <= cnt_q + CNT_W'(1);
    end

    generate
        if (FIXED_SEL != 0) begin : g_fixed
            logic unused_fixed;
            assign sel          = evt_sel_t'(FIXED_SEL);
            assign of_q         = 1'b0;
            assign unused_fixed = ^{sel_we, wrap};
        end else begin : g_prog
            evt_sel_t sel_q;
            always_ff @(posedge clk) begin
                if (rst_n)       sel_q <= '0;
                else if (sel_we) sel_q <= wdata[EVT_SEL_W-1:0];
            end
            assign sel = sel_q;
`ifdef CSR_HPM_OVF_EN
            // A wrap in the same cycle as a software clear keeps OF set.
            always_ff @(posedge clk) begin
                if (rst_n)       of_q <= 1'b0;
                else if (wrap)   of_q <= 1'b1;
                else if (sel_we) of_q <= wdata[31];
            end
`else
            logic unused_wrap;
            assign of_q        = 1'b0;
            assign unused_wrap = wrap;
`endif
        end
    endgenerate

    assign cnt    = cnt_q;
    assign evt_rd = {of_q, {(31 - EVT_SEL_W){1'b0}}, sel};
    assign of     = of_q;

endmodule

// File: rtl/csr_counter_array.sv
// Machine counter CSR block: mcycle, minstret, N_HPM programmable counters,
// mcountinhibit and registered read port. Overflow IRQ under CSR_HPM_OVF_EN.
module csr_counter_array
    import csr_cnt_pkg::*;
#(
    parameter int N_HPM = 4,
    parameter int CNT_W = 64,
    parameter int N_EVT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             csr_re,
    input  logic             csr_we,
    input  logic [11:0]      csr_adr,
    input  logic [31:0]      csr_wdata,
    output logic [31:0]      csr_rdata,
    output logic             csr_hit,
    input  logic             inst_retire,
    input  logic [N_EVT-1:0] evt_in,
    output logic             ovf_irq
);

    localparam int NS = N_HPM + 1;
    // Writable inhibit bits: CY (0), IR (2) and one per implemented hpm counter.
    localparam logic [31:0] INH_MASK = 32'((64'd1 << (N_HPM + 3)) - 64'd8) | 32'h5;

    logic [CNT_W-1:0] mcycle_q;
    logic [31:0]      minh_q;
    logic [CNT_W-1:0] cnt [NS];
    logic [31:0]      evt_rd [NS];
    logic [NS-1:0]    of_vec;
    logic [NS-1:0]    we_lo, we_hi, sel_we;
    logic             mcyc_we_lo, mcyc_we_hi, minh_we;
    logic [11:0]      rd_norm;
    logic [CNT_W-1:0] rd_cnt;
    logic [31:0]      rd_val;
    logic             rd_hit;
    logic             unused_evt0;

    // Only the 0xBxx machine addresses are writable; 0xCxx shadows never match.
    always_comb begin
        mcyc_we_lo = csr_we && (csr_adr == CSR_MCYCLE);
        mcyc_we_hi = csr_we && (csr_adr == (CSR_MCYCLE | CSR_HI_OFS));
        minh_we    = csr_we && (csr_adr == CSR_MCOUNTINH);
        for (int j = 0; j < NS; j++) begin
            we_lo[j]  = csr_we && (csr_adr == cnt_adr(cnt_idx_t'(j)));
            we_hi[j]  = csr_we && (csr_adr == (cnt_adr(cnt_idx_t'(j)) | CSR_HI_OFS));
            sel_we[j] = (j != 0) && csr_we && (csr_adr == evt_adr(cnt_idx_t'(j)));
        end
    end

    always_comb begin
        rd_val  = '0;
        rd_hit  = 1'b0;
        rd_cnt  = '0;
        rd_norm = {CSR_MCYCLE[11:8], 1'b0, csr_adr[6:0]};
        if (csr_adr[11:8] == CSR_MCYCLE[11:8] || csr_adr[11:8] == CSR_CYCLE[11:8]) begin
            if (rd_norm == CSR_MCYCLE) begin
                rd_cnt = mcycle_q;
                rd_hit = 1'b1;
            end
            for (int j = 0; j < NS; j++) begin
                if (rd_norm == cnt_adr(cnt_idx_t'(j))) begin
                    rd_cnt = cnt[j];
                    rd_hit = 1'b1;
                end
            end
            rd_val = csr_adr[7] ? 32'(rd_cnt[CNT_W-1:32]) : rd_cnt[31:0];
        end else if (csr_adr == CSR_MCOUNTINH) begin
            rd_val = minh_q;
            rd_hit = 1'b1;
        end else begin
            for (int j = 1; j < NS; j++) begin
                if (csr_adr == evt_adr(cnt_idx_t'(j))) begin
                    rd_val = evt_rd[j];
                    rd_hit = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            csr_rdata <= '0;
            csr_hit   <= 1'b0;
        end else begin
            csr_rdata <= csr_re ? rd_val : '0;
            csr_hit   <= csr_re && rd_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n)           mcycle_q <= '0;
        else if (mcyc_we_lo) mcycle_q[31:0] <= csr_wdata;
        else if (mcyc_we_hi) mcycle_q[CNT_W-1:32] <= csr_wdata[CNT_W-33:0];
        else if (!minh_q[0]) mcycle_q <= mcycle_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst_n)        minh_q <= '0;
        else if (minh_we) minh_q <= csr_wdata & INH_MASK;
    end

    csr_cnt_slice #(.CNT_W(CNT_W), .N_EVT(1), .FIXED_SEL(1)) u_minstret (
        .clk     (clk),
        .rst_n   (rst_n),
        .inhibit (minh_q[2]),
        .evt     (inst_retire),
        .we_lo   (we_lo[0]),
        .we_hi   (we_hi[0]),
        .sel_we  (sel_we[0]),
        .wdata   (csr_wdata),
        .cnt     (cnt[0]),
        .evt_rd  (evt_rd[0]),
        .of      (of_vec[0])
    );

    for (genvar g = 1; g < NS; g++) begin : g_hpm
        csr_cnt_slice #(.CNT_W(CNT_W), .N_EVT(N_EVT), .FIXED_SEL(0)) u_hpm (
            .clk     (clk),
            .rst_n   (rst_n),
            .inhibit (minh_q[2 + g]),
            .evt     (evt_in),
            .we_lo   (we_lo[g]),
            .we_hi   (we_hi[g]),
            .sel_we  (sel_we[g]),
            .wdata   (csr_wdata),
            .cnt     (cnt[g]),
            .evt_rd  (evt_rd[g]),
            .of      (of_vec[g])
        );
    end

    assign unused_evt0 = ^evt_rd[0];

`ifdef CSR_HPM_OVF_EN
    logic ovf_q;
    always_ff @(posedge clk) begin
        if (rst_n) ovf_q <= 1'b0;
        else       ovf_q <= |of_vec;
    end
    assign ovf_irq = ovf_q;
`else
    logic unused_of;
    assign unused_of = ^of_vec;
    assign ovf_irq   = 1'b0;
`endif

endmodule

// File: tb/tb_csr_counter_array.sv
// Directed bench for csr_counter_array (N_HPM=29) with a reference model and
// a read scoreboard; the OF/ovf_irq steps follow CSR_HPM_OVF_EN.
module tb_csr_counter_array;

    localparam int N_HPM = 29;
    localparam int CNT_W = 64;
    localparam int N_EVT = 8;
`ifdef CSR_HPM_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             csr_re = 1'b0;
    logic             csr_we = 1'b0;
    logic [11:0]      csr_adr = '0;
    logic [31:0]      csr_wdata = '0;
    logic [31:0]      csr_rdata;
    logic             csr_hit;
    logic             inst_retire = 1'b0;
    logic [N_EVT-1:0] evt_in = '0;
    logic             ovf_irq;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        hit;
    } exp_t;
    exp_t sb[$];

    csr_counter_array #(.N_HPM(N_HPM), .CNT_W(CNT_W), .N_EVT(N_EVT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .csr_re      (csr_re),
        .csr_we      (csr_we),
        .csr_adr     (csr_adr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .csr_hit     (csr_hit),
        .inst_retire (inst_retire),
        .evt_in      (evt_in),
        .ovf_irq     (ovf_irq)
    );

    always #5 clk = ~clk;

    // Reference model: slot 0 = minstret, slot j = mhpmcounter(2+j).
    logic [63:0] m_mcycle;
    logic [63:0] m_cnt [N_HPM+1];
    logic [31:0] m_inh;
    logic [7:0]  m_sel [N_HPM+1];
    logic        m_of  [N_HPM+1];

    always @(posedge clk) begin : p_model
        logic inc;
        logic wr;
        logic wrapv [N_HPM+1];
        if (rst_n) begin
            m_mcycle = '0;
            m_inh    = '0;
            for (int j = 0; j <= N_HPM; j++) begin
                m_cnt[j] = '0;
                m_sel[j] = '0;
                m_of[j]  = 1'b0;
            end
        end else begin
            if (csr_we && csr_adr == 12'hB00)      m_mcycle[31:0]  = csr_wdata;
            else if (csr_we && csr_adr == 12'hB80) m_mcycle[63:32] = csr_wdata;
            else if (!m_inh[0])                    m_mcycle        = m_mcycle + 64'd1;
            for (int j = 0; j <= N_HPM; j++) begin
                wrapv[j] = 1'b0;
                if (j == 0) inc = inst_retire;
                else inc = (m_sel[j] >= 8'd1) && (m_sel[j] <= 8'(N_EVT)) && evt_in[m_sel[j] - 8'd1];
                inc = inc && !m_inh[2 + j];
                if (csr_we && csr_adr == 12'(12'hB02 + j))      m_cnt[j][31:0]  = csr_wdata;
                else if (csr_we && csr_adr == 12'(12'hB82 + j)) m_cnt[j][63:32] = csr_wdata;
                else if (inc) begin
                    wrapv[j] = (m_cnt[j] == '1);
                    m_cnt[j] = m_cnt[j] + 64'd1;
                end
            end
            if (csr_we && csr_adr == 12'h320) m_inh = csr_wdata & 32'hFFFF_FFFD;
            for (int j = 1; j <= N_HPM; j++) begin
                wr = csr_we && (csr_adr == 12'(12'h322 + j));
                if (wr) m_sel[j] = csr_wdata[7:0];
                if (OVF) begin
                    if (wrapv[j]) m_of[j] = 1'b1;
                    else if (wr)  m_of[j] = csr_wdata[31];
                end
            end
        end
    end

    function automatic logic [32:0] model_rd(input logic [11:0] a);
        logic [63:0] v;
        int          off;
        off = int'(a[6:0]);
        if (a[11:8] == 4'hB || a[11:8] == 4'hC) begin
            if (off == 0) v = m_mcycle;
            else if (off >= 2 && off <= 2 + N_HPM) v = m_cnt[off - 2];
            else return '0;
            return {1'b1, a[7] ? v[63:32] : v[31:0]};
        end
        if (a == 12'h320) return {1'b1, m_inh};
        for (int j = 1; j <= N_HPM; j++)
            if (a == 12'(12'h322 + j)) return {1'b1, m_of[j], 23'd0, m_sel[j]};
        return '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        e = sb.pop_front();
        check(e.tag, csr_rdata, e.data);
        check({e.tag, "_hit"}, {31'd0, csr_hit}, {31'd0, e.hit});
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] ed, input logic eh, input string tag);
        csr_re  = 1'b1;
        csr_adr = a;
        sb.push_back('{tag, ed, eh});
        tick();
        csr_re  = 1'b0;
        csr_adr = '0;
        pop_check();
    endtask

    task automatic rdm(input logic [11:0] a, input string tag);
        logic [32:0] m;
        m = model_rd(a);
        rd(a, m[31:0], m[32], tag);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_we    = 1'b1;
        csr_adr   = a;
        csr_wdata = d;
        tick();
        csr_we    = 1'b0;
        csr_adr   = '0;
        csr_wdata = '0;
    endtask

    initial begin
        logic [32:0] snap;

        rst_n = 1'b1;
        repeat (2) tick();
        rst_n = 1'b0;
        check("rst_rdata", csr_rdata, 32'd0);
        check("rst_hit", {31'd0, csr_hit}, 32'd0);
        check("rst_irq", {31'd0, ovf_irq}, 32'd0);

        repeat (10) tick();
        rd(12'hB00, 32'd10, 1'b1, "mcycle_10");
        rd(12'hB02, 32'd0, 1'b1, "minstret_0");
        rd(12'hB80, 32'd0, 1'b1, "mcycle_hi_0");
        rdm(12'hC00, "cycle_shadow");

        wr(12'hB80, 32'd0);
        wr(12'hB00, 32'hFFFF_FFFF);
        tick();
        rd(12'hB80, 32'd1, 1'b1, "mcycle_carry_hi");
        rd(12'hB00, 32'd1, 1'b1, "mcycle_carry_lo");

        rd(12'hB01, 32'd0, 1'b0, "unmap_b01");
        rd(12'h321, 32'd0, 1'b0, "unmap_321");
        rd(12'h322, 32'd0, 1'b0, "unmap_322");
        rd(12'hB20, 32'd0, 1'b0, "unmap_b20");
        rd(12'h7C0, 32'd0, 1'b0, "unmap_7c0");

        wr(12'hC02, 32'd1234);
        rd(12'hB02, 32'd0, 1'b1, "shadow_wr_ignored");

        wr(12'h323, 32'd3);
        evt_in = 8'h04;
        repeat (5) tick();
        evt_in = 8'h01;
        repeat (4) tick();
        evt_in = 8'h00;
        rd(12'hB03, 32'd5, 1'b1, "hpm3_sel3");
        wr(12'h323, 32'd9);
        evt_in = 8'hFF;
        repeat (3) tick();
        evt_in = 8'h00;
        rd(12'hB03, 32'd5, 1'b1, "hpm3_sel9_idle");
        rd(12'h323, 32'd9, 1'b1, "mhpmevent3_rd");
        wr(12'h323, 32'd0);
        evt_in = 8'hFF;
        repeat (2) tick();
        evt_in = 8'h00;
        rd(12'hC03, 32'd5, 1'b1, "hpm3_sel0_idle");
        wr(12'h324, 32'd8);
        evt_in = 8'h80;
        repeat (3) tick();
        evt_in = 8'h00;
        rd(12'hB04, 32'd3, 1'b1, "hpm4_sel8");
        wr(12'h324, 32'd0);
        wr(12'h325, 32'h8000_0F02);
        rd(12'h325, OVF ? 32'h8000_0002 : 32'h0000_0002, 1'b1, "mhpmevent5_mask");
        wr(12'h325, 32'd0);

        wr(12'h323, 32'd3);
        wr(12'h320, 32'd5);
        snap = model_rd(12'hB00);
        rd(12'hB00, snap[31:0], 1'b1, "mcycle_frozen_a");
        inst_retire = 1'b1;
        evt_in = 8'h04;
        repeat (20) tick();
        inst_retire = 1'b0;
        evt_in = 8'h00;
        rd(12'hB00, snap[31:0], 1'b1, "mcycle_frozen_b");
        rd(12'hB02, 32'd0, 1'b1, "minstret_frozen");
        rd(12'hC03, 32'd25, 1'b1, "hpm3_uninhibited");
        wr(12'h320, 32'hFFFF_FFFF);
        rd(12'h320, 32'hFFFF_FFFD, 1'b1, "mcountinhibit_mask");
        wr(12'h320, 32'd0);
        inst_retire = 1'b1;
        repeat (3) tick();
        inst_retire = 1'b0;
        rd(12'hC02, 32'd3, 1'b1, "instret_3");

        wr(12'hB83, 32'hFFFF_FFFF);
        wr(12'hB03, 32'hFFFF_FFFF);
        evt_in = 8'h04;
        tick();
        evt_in = 8'h00;
        check("irq_same_edge", {31'd0, ovf_irq}, 32'd0);
        rd(12'hB03, 32'd0, 1'b1, "hpm3_wrap_lo");
        check("irq_after_wrap", {31'd0, ovf_irq}, {31'd0, OVF});
        rd(12'hB83, 32'd0, 1'b1, "hpm3_wrap_hi");
        rd(12'h323, OVF ? 32'h8000_0003 : 32'h0000_0003, 1'b1, "of_set");

        wr(12'hB83, 32'hFFFF_FFFF);
        wr(12'hB03, 32'hFFFF_FFFF);
        csr_we    = 1'b1;
        csr_adr   = 12'h323;
        csr_wdata = 32'd3;
        evt_in    = 8'h04;
        tick();
        csr_we    = 1'b0;
        csr_adr   = '0;
        csr_wdata = '0;
        evt_in    = 8'h00;
        rd(12'h323, OVF ? 32'h8000_0003 : 32'h0000_0003, 1'b1, "of_wrap_beats_clear");
        rd(12'hB03, 32'd0, 1'b1, "hpm3_wrap2");
        wr(12'h323, 32'd3);
        check("irq_hold_at_clear", {31'd0, ovf_irq}, {31'd0, OVF});
        tick();
        check("irq_cleared", {31'd0, ovf_irq}, 32'd0);

        csr_we    = 1'b1;
        csr_re    = 1'b1;
        csr_adr   = 12'hB84;
        csr_wdata = 32'h77;
        snap      = model_rd(12'hB84);
        sb.push_back('{"rd_during_wr", snap[31:0], snap[32]});
        tick();
        csr_we    = 1'b0;
        csr_re    = 1'b0;
        csr_adr   = '0;
        csr_wdata = '0;
        pop_check();
        rd(12'hB84, 32'h77, 1'b1, "hpm4_hi_written");
        rd(12'hB04, 32'd3, 1'b1, "hpm4_lo_kept");

        inst_retire = 1'b1;
        evt_in = 8'h04;
        repeat (3) tick();
        rst_n     = 1'b1;
        csr_we    = 1'b1;
        csr_adr   = 12'hB02;
        csr_wdata = 32'h55;
        tick();
        rst_n       = 1'b0;
        csr_we      = 1'b0;
        csr_adr     = '0;
        csr_wdata   = '0;
        inst_retire = 1'b0;
        evt_in      = 8'h00;
        check("rst2_irq", {31'd0, ovf_irq}, 32'd0);
        rd(12'hB00, 32'd0, 1'b1, "rst2_mcycle");
        rd(12'hB02, 32'd0, 1'b1, "rst2_minstret");
        rd(12'hB03, 32'd0, 1'b1, "rst2_hpm3");
        rd(12'hB84, 32'd0, 1'b1, "rst2_hpm4_hi");
        rd(12'h323, 32'd0, 1'b1, "rst2_mhpmevent3");
        rd(12'h320, 32'd0, 1'b1, "rst2_mcountinhibit");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/csr_counter_array.md
CSR_COUNTER_ARRAY -- requirements
Module: csr_counter_array

Interface
REQ-001 SHALL have parameter N_HPM, default 4: number of programmable counters mhpmcounter3..(3+N_HPM-1), legal range 0..29.
REQ-002 SHALL have parameter CNT_W, default 64: implemented counter width, legal range 33..64.
REQ-003 SHALL have parameter N_EVT, default 8: number of event inputs, legal range 1..255.
REQ-004 SHALL have port clk  in  1: sole clock, all state updated on rising edge.
REQ-005 SHALL have port rst_n  in  1: reset is synchronous and active-high.
REQ-006 SHALL have port csr_re  in  1: CSR read strobe.
REQ-007 SHALL have port csr_we  in  1: CSR write strobe, resolved write data already computed by caller (rw/rs/rc).
REQ-008 SHALL have port csr_adr  in  12: CSR address for read or write.
REQ-009 SHALL have port csr_wdata  in  32: write data.
REQ-010 SHALL have port csr_rdata  out  32: registered read data.
REQ-011 SHALL have port csr_hit  out  1: registered, high when previous csr_re address decoded to this block.
REQ-012 SHALL have port inst_retire  in  1: one-cycle pulse per retired instruction.
REQ-013 SHALL have port evt_in  in  N_EVT: per-cycle event pulses.
REQ-014 SHALL have port ovf_irq  out  1: counter-overflow interrupt request (see Configuration).

Function
REQ-015 SHALL decode mcycle 0xB00, minstret 0xB02, mhpmcounter(3+i) 0xB03+i; high halves at +0x80; mcountinhibit 0x320; mhpmevent(3+i) 0x323+i; read-only shadows cycle 0xC00, instret 0xC02, hpmcounter(3+i) 0xC03+i, high halves 0xC80+.
REQ-016 SHALL return read data one cycle after csr_re; unmapped address: csr_rdata=0, csr_hit=0.
REQ-017 SHALL increment mcycle every cycle, minstret on inst_retire, counter i when evt_in[mhpmevent(3+i)[7:0]-1] is high, each only if its mcountinhibit bit is 0.
REQ-018 SHALL never count for event selector 0 or selector > N_EVT.
REQ-019 SHALL wrap counters from all-ones (CNT_W bits) to zero.
REQ-020 SHALL, on write to a low half, load bits [31:0], keep upper bits, and drop that cycle's increment; on write to a high half, load bits [CNT_W-1:32] from csr_wdata truncated, keep lower bits, drop that cycle's increment.
REQ-021 SHALL read high halves zero-extended above CNT_W-32 bits.
REQ-022 SHALL ignore writes to 0xCxx shadows and to mcountinhibit bit 1; bit 1 reads 0; bits above 2+N_HPM read 0.
REQ-023 SHALL return, for a read in the same cycle as a write/increment to the same register, the pre-update value.
REQ-024 SHALL keep mhpmevent bits [7:0] writable; other bits read 0 except per REQ-030.

Reset
REQ-025 SHALL clear all counters, mcountinhibit, mhpmevent, csr_rdata, csr_hit, ovf_irq when rst_n is high at a clock edge.
REQ-026 SHALL give reset priority over any concurrent write or increment.

Configuration
REQ-027 SHALL compile overflow support only when macro CSR_HPM_OVF_EN is defined.
REQ-028 With CSR_HPM_OVF_EN: mhpmevent(3+i) bit 31 (OF) SHALL set on wrap of counter i, stay set until software writes 0, and a set-wrap in the same cycle as a software clear SHALL leave OF=1.
REQ-029 With CSR_HPM_OVF_EN: ovf_irq SHALL be registered OR of all OF bits, asserting one cycle after the wrap edge.
REQ-030 Without CSR_HPM_OVF_EN: bit 31 SHALL read 0, be unwritable, and ovf_irq SHALL be constant 0.

Structure
REQ-031 SHALL place CSR address constants, counter-index typedefs, and event-selector width in shared package csr_cnt_pkg.
REQ-032 SHALL use one sub-module csr_cnt_slice (single counter, inhibit, event select, write merge, OF bit) instantiated for minstret and each mhpmcounter.

Verification
REQ-033 Reset, run 10 cycles, read 0xB00 -> csr_rdata=10 (+1 for read latency), minstret=0.
REQ-034 Write 0xB80=0, 0xB00=0xFFFFFFFF, next cycle read 0xB80 -> 1, low half 0x00000000 or 1 per cycles elapsed.
REQ-035 mhpmevent3=3, pulse evt_in[2] 5 times, evt_in[0] 4 times -> mhpmcounter3=5; set mhpmevent3=9 with N_EVT=8 -> no further counts.
REQ-036 mcountinhibit=0x5, 20 inst_retire pulses -> mcycle and minstret frozen, hpmcounter3 still counts; write 0x320=0xFFFFFFFF -> reads 0xFFFFFFFD for N_HPM=29.
REQ-037 (CSR_HPM_OVF_EN) preload mhpmcounter3 to 2^CNT_W-1, one event -> counter 0, OF=1, ovf_irq=1 next cycle; write OF=0 -> ovf_irq=0 following cycle.
REQ-038 Assert rst_n during active counting and a concurrent write to 0xB02 -> all counters 0 after edge.
